// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: observes a roll-over counter, timestamps its wraps into
// a small FIFO, keeps a saturating wrap total and flags shadow-model mismatches.
module count_wrap_monitor #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  input  logic [CNT_W-1:0]  start_val,
  input  logic [CNT_W-1:0]  count,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TS_W-1:0]   evt_ts,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              ovf,
  output logic              err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]   mem_q [DEPTH];
  logic [WRAP_W-1:0] total_q, total_d, total_base;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic empty, full, wrap, pop, push, drop, mismatch;

  // Event detection, FIFO handshake and next-state for all counters/flags
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wrap     = !load && enable && (count == '1);
    pop      = !empty && evt_ready;
    // a pop in the same cycle frees the slot the push lands in
    push     = wrap && (!full || pop);
    drop     = wrap && full && !pop;
    mismatch = (count != exp_q);

    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    exp_d = exp_q;
    if (load) begin
      exp_d = start_val;
    end else if (enable) begin
      exp_d = exp_q + CNT_W'(1);
    end

    // clear first, then let same-cycle events re-apply on top of it
    total_base = clr ? '0 : total_q;
    total_d    = (wrap && (total_base != '1)) ? total_base + WRAP_W'(1) : total_base;
    ovf_d      = (clr ? 1'b0 : ovf_q) | drop;
    err_d      = (clr ? 1'b0 : err_q) | mismatch;
  end

  // Control state: timestamp, shadow counter, FIFO pointers, wrap total, flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q     <= '0;
      exp_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      exp_q    <= exp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
    end
  end

  assign evt_valid  = !empty;
  assign evt_ts     = mem_q[rd_ptr_q[AW-1:0]];
  assign wrap_total = total_q;
  assign ovf        = ovf_q;
  assign err        = err_q;

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Observation stage downstream of the 5-bit roll-over counter. It taps the counter's control inputs (`load`, `enable`, `start_val`) and its `count` output. From these it detects roll-over events (max → 0), timestamps them into a small event FIFO drained over a valid/ready port, and keeps a saturating wrap total. It also runs a shadow model of the counter and flags any divergence. All outputs are registered; the block never drives the counter.

## Interface
Parameters:
- `CNT_W`, 5: width of monitored `count`/`start_val`.
- `WRAP_W`, 8: width of `wrap_total`.
- `TS_W`, 16: width of the free-running timestamp.
- `DEPTH`, 4: event FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `load`  in  1  counter load strobe, same cycle as counter sees it.
- `enable`  in  1  counter increment enable.
- `start_val`  in  CNT_W  counter load value.
- `count`  in  CNT_W  counter output.
- `clr`  in  1  clears `wrap_total`, `ovf`, `err`; FIFO untouched.
- `evt_valid`  out  1  FIFO head valid.
- `evt_ready`  in  1  consumer accepts head when high with `evt_valid`.
- `evt_ts`  out  TS_W  timestamp of head event.
- `wrap_total`  out  WRAP_W  saturating count of wraps since reset/clr.
- `ovf`  out  1  sticky: a wrap event was dropped (FIFO full).
- `err`  out  1  sticky: `count` disagreed with shadow model.

## Operation
- Timestamp `ts`: TS_W counter, +1 every cycle, wraps 2^TS_W−1 → 0.
- Wrap event in cycle t: `load`=0, `enable`=1, `count`=2^CNT_W−1. `load`=1 is never a wrap, even when `start_val`=0 and `count`=max.
- On wrap, push `ts`(t) into FIFO.
  - If FIFO is full and no pop occurs in the same cycle: drop the event and set `ovf`.
  - Full with a simultaneous pop: push succeeds, no drop.
- Pop: `evt_valid` && `evt_ready`. FIFO order is strict first-in first-out.
- `evt_ts` holds stable while `evt_valid`=1 and `evt_ready`=0.
- `wrap_total`:
  - +1 per wrap; saturates at 2^WRAP_W−1 (no roll).
  - Dropped events are still counted.
- Shadow model `exp`, updated each cycle:
  - `load` → `start_val`;
  - else `enable` → `exp`+1 mod 2^CNT_W;
  - else hold.
- Check: every cycle out of reset, `count` ≠ `exp` sets `err`. The comparison uses the value for the current cycle, i.e. before this cycle's update.
- `clr` in cycle t: `ovf`, `err` ← 0, and `wrap_total` ← 0.
  - A wrap in the same cycle makes `wrap_total` = 1.
  - A mismatch or drop in the same cycle sets the flag again, so a same-cycle event wins over the clear.
- The FIFO's pointers, the shadow model and `ts` ignore `clr`.

## Timing
- Reset (`rst_n`=0 at an edge), output and state values after that edge:
  - `evt_valid`=0, `evt_ts`=0, `wrap_total`=0, `ovf`=0, `err`=0.
  - `ts`=0, `exp`=0, FIFO empty.
- Reset mid-operation discards queued events. The first cycle after release compares `count` against `exp`=0, which matches the counter's reset value.
- Wrap in cycle t:
  - `evt_valid`=1 and `evt_ts`=ts(t) after edge t when FIFO was empty (1-cycle latency).
  - `wrap_total` increments at edge t.
- Pop at edge t: next head (or `evt_valid`=0) visible after edge t. Back-to-back pops are supported: 1 event/cycle sustained.
- Mismatch in cycle t: `err`=1 after edge t.
- No combinational path from any input to any output.

## Test plan
- Reset, then `enable`=1 for 40 cycles from `count`=0:
  - one wrap at ts=31;
  - `evt_valid` rises at cycle 32 with `evt_ts`=31;
  - `wrap_total`=1, `err`=0.
- `load`=1, `start_val`=0 while `count`=31 with `enable`=1 → no event, `wrap_total` unchanged, `exp`=0, `err`=0.
- `evt_ready`=0, `DEPTH`=4, force 5 wraps (load 31 then enable, repeated):
  - FIFO holds the first 4 timestamps and `ovf`=1, `wrap_total`=5;
  - drain with `evt_ready`=1 → 4 timestamps in order, then `evt_valid`=0.
- FIFO full, wrap coincident with a pop → no drop, `ovf` stays 0, occupancy stays 4.
- Drive `count`=7 while `exp`=6 for one cycle → `err`=1 next cycle; `clr` pulse → `err`=0; `clr` coincident with a mismatch → `err`=1.
- `WRAP_W`=2, 5 wraps → `wrap_total`=3 (saturated); `rst_n`=0 mid-burst → all outputs 0 after the edge, FIFO empty.
